// File: rtl/spi_cmd_sched_pkg.sv
// Shared definitions for the SPI command scheduler: FSM states, command field
// positions and a counter-width helper.
package spi_cmd_sched_pkg;

    typedef enum logic [2:0] {
        SCH_IDLE  = 3'd0,
        SCH_ISSUE = 3'd1,
        SCH_WLOW  = 3'd2,
        SCH_WHIGH = 3'd3,
        SCH_DELAY = 3'd4
    } sch_state_t;

    localparam int unsigned OP_DELAY = 10;
    localparam int unsigned OP_PWR   = 9;
    localparam int unsigned OP_DC    = 8;
    localparam int unsigned CMD_W    = 11;
    localparam int unsigned DIN_W    = 10;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_cmd_sched_if.sv
// CPU-side command port, SPI driver handshake and status flags of the scheduler.
interface spi_cmd_sched_if
    import spi_cmd_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 16
);
    logic                   wr_en;
    logic [CMD_W-1:0]       wr_data;
    logic                   clr_err;
    logic                   spi_cs_n;
    logic                   spi_start;
    logic [DIN_W-1:0]       spi_din;
    logic [$clog2(DEPTH):0] level;
    logic                   full;
    logic                   busy;
    logic                   ovf;
    logic                   tmo;

    modport master (
        output wr_en, wr_data, clr_err, spi_cs_n,
        input  spi_start, spi_din, level, full, busy, ovf, tmo
    );

    modport slave (
        input  wr_en, wr_data, clr_err, spi_cs_n,
        output spi_start, spi_din, level, full, busy, ovf, tmo
    );
endinterface

// File: rtl/spi_cmd_fifo.sv
// Synchronous circular-buffer FIFO with wrapping pointers and an occupancy count.
module spi_cmd_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       push_data,
    output logic [WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Full is judged on the pre-pop level, so a push into a full FIFO drops even if it pops.
    assign full     = (level == (AW+1)'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/spi_cmd_sched.sv
// Command queue and sequencer for the PMOD OLED SPI driver: issues queued bytes as
// start pulses, tracks completion via cs_ and inserts tick-based delays.
module spi_cmd_sched
    import spi_cmd_sched_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned TICK_DIV = 6250,
    parameter int unsigned LOW_TO   = 4
) (
    input  logic           clk,
    input  logic           reset,
    spi_cmd_sched_if.slave bus
);
    localparam int unsigned PRE_W = cnt_width(TICK_DIV);
    localparam int unsigned TO_W  = cnt_width(LOW_TO);

    sch_state_t       state;
    logic [CMD_W-1:0] head;
    logic             pwr;
    logic [7:0]       ticks;
    logic [PRE_W-1:0] pre;
    logic [TO_W-1:0]  wait_cnt;
    logic             pop;
    logic             empty;
    logic             fifo_full;
    logic             ovf_set;
    logic             tmo_set;

    assign pop      = (state == SCH_IDLE) && !empty;
    assign ovf_set  = bus.wr_en && fifo_full;
    assign tmo_set  = (state == SCH_WLOW) && bus.spi_cs_n && (wait_cnt == TO_W'(LOW_TO - 1));
    assign bus.full = fifo_full;
    assign bus.busy = (state != SCH_IDLE) || !empty;

    spi_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (bus.wr_en),
        .pop       (pop),
        .push_data (bus.wr_data),
        .pop_data  (head),
        .level     (bus.level),
        .full      (fifo_full),
        .empty     (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= SCH_IDLE;
            bus.spi_start <= 1'b0;
            bus.spi_din   <= '0;
            pwr           <= 1'b0;
            ticks         <= '0;
            pre           <= '0;
            wait_cnt      <= '0;
        end else begin
            bus.spi_start <= 1'b0;
            unique case (state)
                SCH_IDLE: begin
                    if (!empty) begin
                        pwr      <= head[OP_PWR];
                        ticks    <= head[7:0];
                        pre      <= '0;
                        wait_cnt <= '0;
                        if (head[OP_DELAY]) begin
                            state <= SCH_DELAY;
                        end else begin
                            // Start is registered here so the pulse coincides with ISSUE.
                            state         <= SCH_ISSUE;
                            bus.spi_start <= 1'b1;
                            bus.spi_din   <= {head[OP_PWR], head[OP_DC], head[7:0]};
                        end
                    end
                end
                SCH_ISSUE: state <= pwr ? SCH_IDLE : SCH_WLOW;
                SCH_WLOW: begin
                    if (!bus.spi_cs_n)  state    <= SCH_WHIGH;
                    else if (tmo_set)   state    <= SCH_IDLE;
                    else                wait_cnt <= wait_cnt + 1'b1;
                end
                SCH_WHIGH: begin
                    if (bus.spi_cs_n) state <= SCH_IDLE;
                end
                SCH_DELAY: begin
                    // One extra cycle at ticks==0 makes a zero-tick delay take exactly one cycle.
                    if (ticks == '0) begin
                        state <= SCH_IDLE;
                    end else if (pre == PRE_W'(TICK_DIV - 1)) begin
                        pre   <= '0;
                        ticks <= ticks - 1'b1;
                    end else begin
                        pre <= pre + 1'b1;
                    end
                end
                default: state <= SCH_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.ovf <= 1'b0;
            bus.tmo <= 1'b0;
        end else begin
            if (ovf_set)          bus.ovf <= 1'b1;
            else if (bus.clr_err) bus.ovf <= 1'b0;
            if (tmo_set)          bus.tmo <= 1'b1;
            else if (bus.clr_err) bus.tmo <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_cmd_sched.sv
// Randomized and directed bench for spi_cmd_sched against a transaction-timing reference model.
module tb_spi_cmd_sched;
    localparam int DEPTH    = 16;
    localparam int TICK_DIV = 8;
    localparam int LOW_TO   = 4;
    localparam int NEVER    = 32'h7fff_ffff;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_cmd_sched_if #(.DEPTH(DEPTH)) bus ();

    spi_cmd_sched #(
        .DEPTH    (DEPTH),
        .TICK_DIV (TICK_DIV),
        .LOW_TO   (LOW_TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: pending queue plus the cycle at which the sequencer is next free.
    logic [10:0] q[$];
    int          cyc = 0;
    bit          armed = 1'b0;
    int          free_at, start_at, tmo_at, cs_lo_s, cs_lo_e;
    logic [9:0]  din_exp, din_pend;
    bit          ovf_m, tmo_m;
    int          drv_mode;
    int          last_start, n_starts, delay_pop_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs, then advance the model across the edge.
    task automatic step(input bit rst, input bit we, input logic [10:0] d, input bit clr);
        bit          was_full, ovf_s, tmo_s;
        logic [10:0] e;
        int          s, a, b;
        @(posedge clk);
        #1;
        reset        = rst;
        bus.wr_en    = we;
        bus.wr_data  = d;
        bus.clr_err  = clr;
        bus.spi_cs_n = !(cyc >= cs_lo_s && cyc < cs_lo_e);
        if (cyc == start_at) din_exp = din_pend;
        if (armed) begin
            check("spi_start", 32'(bus.spi_start), 32'(cyc == start_at));
            check("spi_din",   32'(bus.spi_din),   32'(din_exp));
            check("level",     32'(bus.level),     32'(q.size()));
            check("full",      32'(bus.full),      32'(q.size() == DEPTH));
            check("busy",      32'(bus.busy),      32'((cyc < free_at) || (q.size() != 0)));
            check("ovf",       32'(bus.ovf),       32'(ovf_m));
            check("tmo",       32'(bus.tmo),       32'(tmo_m));
        end
        if (bus.spi_start === 1'b1) begin
            last_start = cyc;
            n_starts++;
        end
        if (rst) begin
            q.delete();
            free_at  = cyc + 1;
            start_at = -1;
            tmo_at   = -1;
            cs_lo_s  = NEVER;
            cs_lo_e  = NEVER;
            din_exp  = '0;
            ovf_m    = 1'b0;
            tmo_m    = 1'b0;
            armed    = 1'b1;
        end else begin
            was_full = (q.size() == DEPTH);
            ovf_s    = we && was_full;
            tmo_s    = (cyc == tmo_at);
            if (cyc >= free_at && q.size() != 0) begin
                e = q.pop_front();
                if (e[10]) begin
                    delay_pop_cyc = cyc;
                    free_at = cyc + int'(e[7:0]) * TICK_DIV + 2;
                end else begin
                    s        = cyc + 1;
                    start_at = s;
                    din_pend = e[9:0];
                    if (e[9]) begin
                        free_at = s + 1;
                    end else if (drv_mode == 0) begin
                        a       = int'($urandom_range(LOW_TO, 1));
                        b       = int'($urandom_range(4, 1));
                        cs_lo_s = s + a;
                        cs_lo_e = s + a + b;
                        free_at = s + a + b + 1;
                    end else if (drv_mode == 1) begin
                        tmo_at  = s + LOW_TO;
                        free_at = s + LOW_TO + 1;
                    end else begin
                        cs_lo_s = s + 1;
                        cs_lo_e = NEVER;
                        free_at = NEVER;
                    end
                end
            end
            if (we && !was_full) q.push_back(d);
            ovf_m = ovf_s ? 1'b1 : (clr ? 1'b0 : ovf_m);
            tmo_m = tmo_s ? 1'b1 : (clr ? 1'b0 : tmo_m);
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 11'h000, 1'b0);
    endtask

    initial begin
        int          t, k, starts0;
        logic [10:0] d;
        logic [7:0]  bv;
        reset        = 1'b1;
        bus.wr_en    = 1'b0;
        bus.wr_data  = '0;
        bus.clr_err  = 1'b0;
        bus.spi_cs_n = 1'b1;
        drv_mode     = 0;
        n_starts     = 0;
        last_start   = -1;
        step(1'b1, 1'b0, 11'h000, 1'b0);
        step(1'b1, 1'b0, 11'h000, 1'b0);
        idle(3);

        // 1: normal command, two-cycle push-to-start latency
        t = cyc;
        step(1'b0, 1'b1, 11'h0AF, 1'b0);
        idle(14);
        check("t1_latency", 32'(last_start - t), 32'd2);

        // 2: power-on command needs no cs_ handshake
        t = cyc;
        step(1'b0, 1'b1, 11'h200, 1'b0);
        idle(5);
        check("t2_latency", 32'(last_start - t), 32'd2);

        // 3: two-tick delay ahead of a data byte
        step(1'b0, 1'b1, 11'h402, 1'b0);
        step(1'b0, 1'b1, 11'h155, 1'b0);
        idle(30);
        check("t3_delay_gap", 32'(last_start - delay_pop_cyc), 32'd19);

        // 4: stalled driver, 17 back-to-back pushes overflow the 16-deep queue
        drv_mode = 2;
        step(1'b0, 1'b1, 11'h011, 1'b0);
        idle(5);
        starts0 = n_starts;
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 11'(i + 'h20), 1'b0);
        idle(3);
        check("t4_level", 32'(bus.level), 32'd16);
        check("t4_full",  32'(bus.full),  32'd1);
        check("t4_ovf",   32'(bus.ovf),   32'd1);
        check("t4_starts", 32'(n_starts - starts0), 32'd0);
        step(1'b1, 1'b0, 11'h000, 1'b0);
        idle(2);

        // 5: cs_ never falls -> timeout, next entry still issues, clr_err clears tmo
        drv_mode = 1;
        t = cyc;
        step(1'b0, 1'b1, 11'h0AA, 1'b0);
        idle(LOW_TO + 2);
        check("t5_tmo_pre", 32'(bus.tmo), 32'd0);
        idle(1);
        check("t5_tmo_set", 32'(bus.tmo), 32'd1);
        check("t5_tmo_lat", 32'(cyc - 1 - last_start), 32'(LOW_TO + 1));
        starts0 = n_starts;
        step(1'b0, 1'b1, 11'h0BB, 1'b0);
        idle(10);
        check("t5_next_issued", 32'(n_starts - starts0), 32'd1);
        step(1'b0, 1'b0, 11'h000, 1'b1);
        idle(1);
        check("t5_tmo_clr", 32'(bus.tmo), 32'd0);

        // 6: reset while waiting for cs_ to rise with three entries queued
        drv_mode = 2;
        step(1'b0, 1'b1, 11'h033, 1'b0);
        idle(4);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 11'(i + 'h40), 1'b0);
        idle(1);
        check("t6_level_pre", 32'(bus.level), 32'd3);
        step(1'b1, 1'b0, 11'h000, 1'b0);
        idle(1);
        check("t6_level", 32'(bus.level), 32'd0);
        check("t6_start", 32'(bus.spi_start), 32'd0);
        check("t6_busy",  32'(bus.busy), 32'd0);
        starts0 = n_starts;
        idle(10);
        check("t6_no_start", 32'(n_starts - starts0), 32'd0);

        // Random traffic with mixed driver behaviour and occasional bursts/resets
        for (int i = 0; i < 3000; i++) begin
            drv_mode = ($urandom_range(7, 0) == 0) ? 1 : 0;
            bv = 8'($urandom);
            k  = int'($urandom_range(5, 0));
            if (k == 0)      d = {3'b100, 8'($urandom_range(3, 0))};
            else if (k == 1) d = {2'b01, 1'($urandom), bv};
            else             d = {2'b00, 1'($urandom), bv};
            if ((i / 200) % 3 == 2)
                step(1'b0, $urandom_range(3, 0) != 0, d, $urandom_range(30, 0) == 0);
            else
                step($urandom_range(999, 0) == 0, $urandom_range(3, 0) == 0, d,
                     $urandom_range(30, 0) == 0);
        end
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
